alu_mul_sequencer: RTL

- Multi-cycle controller that computes the low XLEN bits of A*B (RV32M MUL) by sequencing the existing shared combinational ALU through add, shift-left and shift-right steps (shift-add algorithm).
- Sits beside the execute stage and owns the ALU input mux.
- When idle, it forwards the pipeline's ALU request unchanged.
- When busy, it takes the ALU and stalls the pipeline.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_mul_sequencer_if.sv | 29 ++
 rtl/alu_mul_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Opcodes of the shared execute-stage ALU and the multiply sequencer state encoding.
package alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_SLL = 4'b0100;
   localparam logic [3:0] ALU_XOR = 4'b0101;
   localparam logic [3:0] ALU_SLT = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1000;

   typedef enum logic [2:0] {IDLE, EVAL, ADD, SHL, SHR, DONE} mul_state_e;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Bundle of multiply request/response, pipeline ALU request and shared ALU port.
interface alu_mul_sequencer_if #(parameter int XLEN = 32);

   logic            Start;
   logic [XLEN-1:0] MulA;
   logic [XLEN-1:0] MulB;
   logic            Busy;
   logic            Done;
   logic [XLEN-1:0] Result;
   logic [3:0]      Pipe_ALU_Control;
   logic [XLEN-1:0] Pipe_SrcA;
   logic [XLEN-1:0] Pipe_SrcB;
   logic [3:0]      ALU_Control;
   logic [XLEN-1:0] SrcA;
   logic [XLEN-1:0] SrcB;
   logic [XLEN-1:0] ALUOut;
   logic            Zero;

   modport slave (
      input  Start, MulA, MulB, Pipe_ALU_Control, Pipe_SrcA, Pipe_SrcB, ALUOut, Zero,
      output Busy, Done, Result, ALU_Control, SrcA, SrcB
   );

   modport master (
      output Start, MulA, MulB, Pipe_ALU_Control, Pipe_SrcA, Pipe_SrcB, ALUOut, Zero,
      input  Busy, Done, Result, ALU_Control, SrcA, SrcB
   );

endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier (low XLEN bits of A*B) that borrows the shared ALU while busy
// and forwards the pipeline's ALU request when idle.
module alu_mul_sequencer
   import alu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter bit EARLY_TERM = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   alu_mul_sequencer_if.slave  bus
);

   localparam logic [5:0] CNT_LAST = 6'(XLEN - 1);

   mul_state_e      state_q;
   logic [XLEN-1:0] p_q, mcand_q, mplier_q, result_q;
   logic [5:0]      cnt_q;
   logic            busy_q, done_q;

   logic eval_fin, shr_fin;

   // EVAL sees the loaded multiplier; SHR decides on the freshly shifted value from the ALU.
   assign eval_fin = EARLY_TERM && (mplier_q == '0);
   assign shr_fin  = EARLY_TERM ? bus.Zero : (cnt_q == CNT_LAST);

   always_comb begin
      bus.ALU_Control = bus.Pipe_ALU_Control;
      bus.SrcA        = bus.Pipe_SrcA;
      bus.SrcB        = bus.Pipe_SrcB;
      unique case (state_q)
         EVAL: begin
            bus.ALU_Control = ALU_ADD;
            bus.SrcA        = '0;
            bus.SrcB        = '0;
         end
         ADD: begin
            bus.ALU_Control = ALU_ADD;
            bus.SrcA        = p_q;
            bus.SrcB        = mcand_q;
         end
         SHL: begin
            bus.ALU_Control = ALU_SLL;
            bus.SrcA        = mcand_q;
            bus.SrcB        = XLEN'(1);
         end
         SHR: begin
            bus.ALU_Control = ALU_SRL;
            bus.SrcA        = mplier_q;
            bus.SrcB        = XLEN'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         p_q      <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: if (bus.Start) begin
               p_q      <= '0;
               mcand_q  <= bus.MulA;
               mplier_q <= bus.MulB;
               cnt_q    <= '0;
               busy_q   <= 1'b1;
               state_q  <= EVAL;
            end
            EVAL: if (eval_fin) begin
               result_q <= p_q;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
               state_q  <= DONE;
            end else begin
               state_q  <= mplier_q[0] ? ADD : SHL;
            end
            ADD: begin
               p_q     <= bus.ALUOut;
               state_q <= SHL;
            end
            SHL: begin
               mcand_q <= bus.ALUOut;
               state_q <= SHR;
            end
            SHR: begin
               mplier_q <= bus.ALUOut;
               cnt_q    <= cnt_q + 6'd1;
               if (shr_fin) begin
                  result_q <= p_q;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  state_q  <= bus.ALUOut[0] ? ADD : SHL;
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.Busy   = busy_q;
   assign bus.Done   = done_q;
   assign bus.Result = result_q;

endmodule
